id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage pipelined RISC-V core, directly downstream of the IF stage.
- Consumes the IF/ID register outputs and decodes the instruction into control signals and an immediate.
- Reads the 32x32 register file, with the write port driven from WB.
- Detects load-use hazards, drives pc_write/if_id_write back to IF, and registers all results into the ID/EX pipeline register.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/reg_file.sv | 46 ++++
 rtl/id_stage.sv | 181 ++++++++++++++++++
 tb/tb_id_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, ALU op encodings
// and the ID/EX pipeline bundle.
package riscv_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
    logic              jump;
    logic              illegal;
  } id_ex_t;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, 2 async reads, 1 write, x0 reads zero.
// RF_WB_BYPASS_EN: posedge write + read bypass; else negedge write.
module reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

`ifdef RF_WB_BYPASS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
`else
  always_ff @(negedge clk_i or negedge rst_ni) begin
`endif
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
`ifdef RF_WB_BYPASS_EN
    if (we_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (we_i && waddr_i == raddr2_i) rdata2_o = wdata_i;
`endif
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: control decode, immediates, regfile read,
// load-use stall and ID/EX register. Option: RF_WB_BYPASS_EN.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_id_pc_plus4,
  input  logic [31:0]     if_id_instr,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            id_ex_flush,
  output logic            pc_write,
  output logic            if_id_write,
  output logic [XLEN-1:0] id_ex_pc_plus4,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b5,
  output logic [1:0]      id_ex_alu_op,
  output logic            id_ex_alu_src,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_mem_to_reg,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic            id_ex_illegal
);

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2;
  logic [XLEN-1:0] rd1, rd2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic is_r, is_imm, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_auipc;
  logic uses_rs1, uses_rs2, stall;
  id_ex_t dec, id_ex_d, id_ex_q;

  assign ins = if_id_instr;
  assign opc = ins[6:0];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk_i    (clk),
    .rst_ni   (reset),
    .we_i     (wb_reg_write),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  assign is_r     = opc == OP_R;
  assign is_imm   = opc == OP_IMM;
  assign is_ld    = opc == OP_LOAD;
  assign is_st    = opc == OP_STORE;
  assign is_br    = opc == OP_BRANCH;
  assign is_jal   = opc == OP_JAL;
  assign is_jalr  = opc == OP_JALR;
  assign is_lui   = opc == OP_LUI;
  assign is_auipc = opc == OP_AUIPC;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'h000};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    dec.pc_plus4 = if_id_pc_plus4;
    dec.rs1_data = rd1;
    dec.rs2_data = rd2;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = ins[11:7];
    dec.funct3   = ins[14:12];
    dec.funct7b5 = ins[30];
    unique case (1'b1)
      is_r: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_OP_R;
      end
      is_imm: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_OP_I;
        dec.imm       = imm_i;
      end
      is_ld: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm        = imm_i;
      end
      is_st: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_s;
      end
      is_br: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_OP_BR;
        dec.imm    = imm_b;
      end
      is_jal: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = imm_j;
      end
      is_jalr: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_i;
      end
      is_lui, is_auipc: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load result is not ready until MEM, so a dependent op waits one cycle.
  assign uses_rs1 = !(is_lui || is_auipc || is_jal);
  assign uses_rs2 = is_r || is_st || is_br;
  assign stall = id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                 ((id_ex_q.rd == rs1 && uses_rs1) ||
                  (id_ex_q.rd == rs2 && uses_rs2));

  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  always_comb begin
    id_ex_d = dec;
    if (id_ex_flush || stall) id_ex_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) id_ex_q <= '0;
    else        id_ex_q <= id_ex_d;
  end

  assign id_ex_pc_plus4   = id_ex_q.pc_plus4;
  assign id_ex_rs1_data   = id_ex_q.rs1_data;
  assign id_ex_rs2_data   = id_ex_q.rs2_data;
  assign id_ex_imm        = id_ex_q.imm;
  assign id_ex_rs1        = id_ex_q.rs1;
  assign id_ex_rs2        = id_ex_q.rs2;
  assign id_ex_rd         = id_ex_q.rd;
  assign id_ex_funct3     = id_ex_q.funct3;
  assign id_ex_funct7b5   = id_ex_q.funct7b5;
  assign id_ex_alu_op     = id_ex_q.alu_op;
  assign id_ex_alu_src    = id_ex_q.alu_src;
  assign id_ex_reg_write  = id_ex_q.reg_write;
  assign id_ex_mem_read   = id_ex_q.mem_read;
  assign id_ex_mem_write  = id_ex_q.mem_write;
  assign id_ex_mem_to_reg = id_ex_q.mem_to_reg;
  assign id_ex_branch     = id_ex_q.branch;
  assign id_ex_jump       = id_ex_q.jump;
  assign id_ex_illegal    = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage.
module tb_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_ex_flush;
  logic        pc_write, if_id_write;
  logic [31:0] id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic [1:0]  id_ex_alu_op;
  logic        id_ex_alu_src, id_ex_reg_write, id_ex_mem_read;
  logic        id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch;
  logic        id_ex_jump, id_ex_illegal;

  int checks = 0;
  int errors = 0;

  id_stage dut (
    .clk              (clk),
    .reset            (reset),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_instr      (if_id_instr),
    .wb_reg_write     (wb_reg_write),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .id_ex_flush      (id_ex_flush),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .id_ex_pc_plus4   (id_ex_pc_plus4),
    .id_ex_rs1_data   (id_ex_rs1_data),
    .id_ex_rs2_data   (id_ex_rs2_data),
    .id_ex_imm        (id_ex_imm),
    .id_ex_rs1        (id_ex_rs1),
    .id_ex_rs2        (id_ex_rs2),
    .id_ex_rd         (id_ex_rd),
    .id_ex_funct3     (id_ex_funct3),
    .id_ex_funct7b5   (id_ex_funct7b5),
    .id_ex_alu_op     (id_ex_alu_op),
    .id_ex_alu_src    (id_ex_alu_src),
    .id_ex_reg_write  (id_ex_reg_write),
    .id_ex_mem_read   (id_ex_mem_read),
    .id_ex_mem_write  (id_ex_mem_write),
    .id_ex_mem_to_reg (id_ex_mem_to_reg),
    .id_ex_branch     (id_ex_branch),
    .id_ex_jump       (id_ex_jump),
    .id_ex_illegal    (id_ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // controls packed: reg_write,mem_read,mem_write,mem_to_reg,
  // branch,jump,alu_src,illegal,alu_op[1:0]
  function automatic logic [9:0] ctl();
    return {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
            id_ex_mem_to_reg, id_ex_branch, id_ex_jump,
            id_ex_alu_src, id_ex_illegal, id_ex_alu_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    if_id_pc_plus4 = 32'h0;
    if_id_instr    = 32'h00000013;
    wb_reg_write   = 1'b0;
    wb_rd          = 5'd0;
    wb_data        = 32'h0;
    id_ex_flush    = 1'b0;
    #1;
    chk("rst_ctl", {22'd0, ctl()}, 32'h0);
    chk("rst_imm", id_ex_imm, 32'h0);
    chk("rst_rd", {27'd0, id_ex_rd}, 32'h0);
    chk("rst_pcw", {31'd0, pc_write}, 32'h1);
    chk("rst_ifw", {31'd0, if_id_write}, 32'h1);
    step();
    reset = 1'b1;

    // addi x1,x0,5 ; WB writes x1=0x11 in the same cycle
    if_id_instr    = 32'h00500093;
    if_id_pc_plus4 = 32'h104;
    wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h11;
    #1;
    chk("addi_pcw", {31'd0, pc_write}, 32'h1);
    chk("addi_ifw", {31'd0, if_id_write}, 32'h1);
    step();
    chk("addi_ctl", {22'd0, ctl()}, {22'd0, 10'b1000001011});
    chk("addi_imm", id_ex_imm, 32'd5);
    chk("addi_rd", {27'd0, id_ex_rd}, 32'd1);
    chk("addi_pc4", id_ex_pc_plus4, 32'h104);
    chk("addi_rs1d", id_ex_rs1_data, 32'h0);

    // add x3,x1,x2 with same-cycle WB write x2
    if_id_instr    = 32'h002081B3;
    if_id_pc_plus4 = 32'h108;
    wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
    step();
    wb_reg_write = 1'b0;
    chk("add_rs2d", id_ex_rs2_data, 32'hDEADBEEF);
    chk("add_rs1d", id_ex_rs1_data, 32'h11);
    chk("add_aluop", {30'd0, id_ex_alu_op}, 32'd2);
    chk("add_rd", {27'd0, id_ex_rd}, 32'd3);
    chk("add_alusrc", {31'd0, id_ex_alu_src}, 32'd0);

    // lw x5,0(x1) then add x6,x5,x0 -> one-cycle stall
    if_id_instr = 32'h0000A283;
    step();
    chk("lw_ctl", {22'd0, ctl()}, {22'd0, 10'b1101001000});
    chk("lw_rd", {27'd0, id_ex_rd}, 32'd5);
    chk("lw_rs1d", id_ex_rs1_data, 32'h11);
    if_id_instr = 32'h00028333;
    #1;
    chk("lu_pcw0", {31'd0, pc_write}, 32'h0);
    chk("lu_ifw0", {31'd0, if_id_write}, 32'h0);
    step();
    chk("lu_bub_ctl", {22'd0, ctl()}, 32'h0);
    chk("lu_bub_rd", {27'd0, id_ex_rd}, 32'h0);
    chk("lu_pcw1", {31'd0, pc_write}, 32'h1);
    step();
    chk("lu_add_ctl", {22'd0, ctl()}, {22'd0, 10'b1000000010});
    chk("lu_add_rd", {27'd0, id_ex_rd}, 32'd6);

    // stall and flush together
    if_id_instr = 32'h0000A283;
    step();
    if_id_instr = 32'h00028333;
    id_ex_flush = 1'b1;
    #1;
    chk("sf_pcw", {31'd0, pc_write}, 32'h0);
    step();
    chk("sf_ctl", {22'd0, ctl()}, 32'h0);
    chk("sf_rd", {27'd0, id_ex_rd}, 32'h0);
    // flush alone on a valid add
    if_id_instr = 32'h002081B3;
    #1;
    chk("fl_pcw", {31'd0, pc_write}, 32'h1);
    step();
    id_ex_flush = 1'b0;
    chk("fl_ctl", {22'd0, ctl()}, 32'h0);
    chk("fl_rd", {27'd0, id_ex_rd}, 32'h0);
    chk("fl_rs2d", id_ex_rs2_data, 32'h0);

    // immediates
    if_id_instr = 32'hFE000CE3;
    step();
    chk("beq_imm", id_ex_imm, 32'hFFFFFFF8);
    chk("beq_ctl", {22'd0, ctl()}, {22'd0, 10'b0000100001});
    if_id_instr = 32'h123453B7;
    step();
    chk("lui_imm", id_ex_imm, 32'h12345000);
    chk("lui_rd", {27'd0, id_ex_rd}, 32'd7);
    if_id_instr = 32'h001000EF;
    step();
    chk("jal_imm", id_ex_imm, 32'h00000800);
    chk("jal_ctl", {22'd0, ctl()}, {22'd0, 10'b1000010000});

    // unknown opcode
    if_id_instr = 32'h0000007F;
    step();
    chk("ill_ctl", {22'd0, ctl()}, {22'd0, 10'b0000000100});

    // write to x0 is dropped; add x3,x0,x0 reads zero
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    if_id_instr = 32'h000001B3;
    step();
    wb_reg_write = 1'b0;
    chk("x0_same", id_ex_rs1_data, 32'h0);
    step();
    chk("x0_rs1", id_ex_rs1_data, 32'h0);
    chk("x0_rs2", id_ex_rs2_data, 32'h0);

    // async reset mid-stall
    if_id_instr = 32'h0000A283;
    if_id_pc_plus4 = 32'h200;
    step();
    if_id_instr = 32'h00028333;
    #1;
    chk("ms_pcw0", {31'd0, pc_write}, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    chk("ms_ctl", {22'd0, ctl()}, 32'h0);
    chk("ms_pc4", id_ex_pc_plus4, 32'h0);
    chk("ms_rs1d", id_ex_rs1_data, 32'h0);
    chk("ms_pcw1", {31'd0, pc_write}, 32'h1);
    chk("ms_ifw1", {31'd0, if_id_write}, 32'h1);
    step();
    reset = 1'b1;
    // registers were cleared too
    if_id_instr = 32'h002081B3;
    step();
    chk("ms_x1", id_ex_rs1_data, 32'h0);
    chk("ms_x2", id_ex_rs2_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
